// File: rtl/sample_sequencer.sv
// sample_sequencer
//
// Per-sample control sequencer for an audio path: on each sampleTick it reads one
// sample from the ADC, optionally routes it through an effect block, and writes the
// result to the DAC. Every stage has a watchdog so a stuck peripheral cannot hang
// the sequencer past one sample period.
//
// Ports
//   sysClk       in   system clock (single domain)
//   rstN         in   asynchronous active-low reset
//   sampleTick   in   one-cycle pulse per sample period
//   bypass       in   1 = skip effect stage (sampled when the ADC handshake completes)
//   clrStatus    in   synchronous clear of overrunCnt / timeoutFlag
//   adcReq       out  ADC read request (level)
//   adcAck       in   ADC data valid (one cycle)
//   adcData      in   ADC sample
//   fxStart      out  effect start (one-cycle pulse)
//   fxIn         out  captured ADC sample presented to the effect
//   fxDone       in   effect result valid (one cycle)
//   fxOut        in   effect result
//   dacReq       out  DAC write request (level)
//   dacAck       in   DAC accepted dacData (one cycle)
//   dacData      out  sample to DAC, held until the next write
//   busy         out  high whenever the sequencer is not idle
//   overrunCnt   out  saturating count of ticks dropped while busy
//   timeoutFlag  out  sticky: a stage watchdog expired
//
// All outputs are registered and updated from the single FSM process.

module sample_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic              sysClk,
  input  logic              rstN,
  input  logic              sampleTick,
  input  logic              bypass,
  input  logic              clrStatus,
  output logic              adcReq,
  input  logic              adcAck,
  input  logic [DATA_W-1:0] adcData,
  output logic              fxStart,
  output logic [DATA_W-1:0] fxIn,
  input  logic              fxDone,
  input  logic [DATA_W-1:0] fxOut,
  output logic              dacReq,
  input  logic              dacAck,
  output logic [DATA_W-1:0] dacData,
  output logic              busy,
  output logic [7:0]        overrunCnt,
  output logic              timeoutFlag
);

  // Watchdog wide enough to hold TIMEOUT itself.
  localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0] WdOne  = WdW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAdc,
    StFx,
    StDac
  } stateT;

  stateT          state;
  logic [WdW-1:0] wdCnt;
  logic           wdExpired;
  logic           tickDrop;

  // The watchdog counts cycles already spent in the stage; the stage is abandoned on
  // the edge that would make it TIMEOUT, so a stage lasts at most TIMEOUT cycles.
  always_comb begin
    wdExpired = (state != StIdle) && (wdCnt == WdLast);
    tickDrop  = sampleTick && (state != StIdle);
  end

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) begin
      state       <= StIdle;
      adcReq      <= 1'b0;
      fxStart     <= 1'b0;
      fxIn        <= '0;
      dacReq      <= 1'b0;
      dacData     <= '0;
      busy        <= 1'b0;
      overrunCnt  <= 8'd0;
      timeoutFlag <= 1'b0;
      wdCnt       <= '0;
    end else begin
      // fxStart is a pulse: only the ADC->FX transition raises it, for one cycle.
      fxStart <= 1'b0;

      // Status: a drop in the same cycle as a clear still counts.
      if (tickDrop) begin
        if (overrunCnt != 8'hFF) begin
          overrunCnt <= overrunCnt + 8'd1;
        end
      end else if (clrStatus) begin
        overrunCnt <= 8'd0;
      end

      // A watchdog expiry below overrides this clear, since it is assigned later.
      if (clrStatus) begin
        timeoutFlag <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          wdCnt <= '0;
          if (sampleTick) begin
            state  <= StAdc;
            adcReq <= 1'b1;
            busy   <= 1'b1;
          end
        end

        StAdc: begin
          if (adcAck) begin
            fxIn   <= adcData;
            adcReq <= 1'b0;
            wdCnt  <= '0;
            if (bypass) begin
              dacData <= adcData;
              dacReq  <= 1'b1;
              state   <= StDac;
            end else begin
              fxStart <= 1'b1;
              state   <= StFx;
            end
          end else if (wdExpired) begin
            state       <= StIdle;
            adcReq      <= 1'b0;
            dacReq      <= 1'b0;
            busy        <= 1'b0;
            timeoutFlag <= 1'b1;
            wdCnt       <= '0;
          end else begin
            wdCnt <= wdCnt + WdOne;
          end
        end

        StFx: begin
          if (fxDone) begin
            dacData <= fxOut;
            dacReq  <= 1'b1;
            state   <= StDac;
            wdCnt   <= '0;
          end else if (wdExpired) begin
            state       <= StIdle;
            adcReq      <= 1'b0;
            dacReq      <= 1'b0;
            busy        <= 1'b0;
            timeoutFlag <= 1'b1;
            wdCnt       <= '0;
          end else begin
            wdCnt <= wdCnt + WdOne;
          end
        end

        StDac: begin
          if (dacAck) begin
            dacReq <= 1'b0;
            busy   <= 1'b0;
            state  <= StIdle;
            wdCnt  <= '0;
          end else if (wdExpired) begin
            // dacData is deliberately left as-is: the DAC keeps the last good value.
            state       <= StIdle;
            adcReq      <= 1'b0;
            dacReq      <= 1'b0;
            busy        <= 1'b0;
            timeoutFlag <= 1'b1;
            wdCnt       <= '0;
          end else begin
            wdCnt <= wdCnt + WdOne;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer. Expected DAC/effect values are pushed into scoreboard
// queues when a sample is launched and popped when the DUT raises dacReq.

module tb_sample_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 400;

  logic          sysClk = 1'b0;
  logic          rstN;
  logic          sampleTick;
  logic          bypass;
  logic          clrStatus;
  logic          adcReq;
  logic          adcAck;
  logic [DW-1:0] adcData;
  logic          fxStart;
  logic [DW-1:0] fxIn;
  logic          fxDone;
  logic [DW-1:0] fxOut;
  logic          dacReq;
  logic          dacAck;
  logic [DW-1:0] dacData;
  logic          busy;
  logic [7:0]    overrunCnt;
  logic          timeoutFlag;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] expDac[$];
  logic [DW-1:0] expFx[$];

  sample_sequencer #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .sysClk     (sysClk),
    .rstN       (rstN),
    .sampleTick (sampleTick),
    .bypass     (bypass),
    .clrStatus  (clrStatus),
    .adcReq     (adcReq),
    .adcAck     (adcAck),
    .adcData    (adcData),
    .fxStart    (fxStart),
    .fxIn       (fxIn),
    .fxDone     (fxDone),
    .fxOut      (fxOut),
    .dacReq     (dacReq),
    .dacAck     (dacAck),
    .dacData    (dacData),
    .busy       (busy),
    .overrunCnt (overrunCnt),
    .timeoutFlag(timeoutFlag)
  );

  always #5 sysClk = ~sysClk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  // Launch one sample with immediate responders: ADC acks while adcReq is seen, the
  // effect answers the cycle after its start pulse. Returns edges from the tick edge to
  // dacReq, then acks the DAC for one cycle.
  task automatic run_sample(input logic [DW-1:0] a, input logic [DW-1:0] f, input logic byp,
                            output int lat, output bit sawStart, output bit gotReq,
                            output logic [DW-1:0] dacSeen, output logic [DW-1:0] fxSeen);
    bit startPrev;
    startPrev  = 1'b0;
    lat        = 0;
    sawStart   = 1'b0;
    gotReq     = 1'b0;
    dacSeen    = '0;
    fxSeen     = '0;
    bypass     = byp;
    adcData    = a;
    fxOut      = f;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (fxStart) sawStart = 1'b1;
      if (dacReq) begin
        lat     = n;
        gotReq  = 1'b1;
        dacSeen = dacData;
        fxSeen  = fxIn;
        break;
      end
      adcAck    = adcReq;
      fxDone    = startPrev;
      startPrev = fxStart;
      step();
    end
    adcAck = 1'b0;
    fxDone = 1'b0;
    if (gotReq) begin
      dacAck = 1'b1;
      step();
      dacAck = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    step();
    step();
    checks++; if (adcReq !== 1'b0) begin errors++; $display("FAIL reset_adcReq got %0b want 0", adcReq); end
    checks++; if (fxStart !== 1'b0) begin errors++; $display("FAIL reset_fxStart got %0b want 0", fxStart); end
    checks++; if (dacReq !== 1'b0) begin errors++; $display("FAIL reset_dacReq got %0b want 0", dacReq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (dacData !== 16'h0) begin errors++; $display("FAIL reset_dacData got %h want 0", dacData); end
    checks++; if (fxIn !== 16'h0) begin errors++; $display("FAIL reset_fxIn got %h want 0", fxIn); end
    checks++; if (overrunCnt !== 8'd0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrunCnt); end
    checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", timeoutFlag); end
    rstN = 1'b1;
    step();
  endtask

  // Effect path with each response one cycle after the request becomes visible.
  task automatic test_fx_path();
    logic [DW-1:0] e;
    expFx.push_back(16'h1234);
    expDac.push_back(16'hABCD);
    bypass     = 1'b0;
    adcData    = 16'h1234;
    fxOut      = 16'hABCD;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    checks++; if (adcReq !== 1'b1) begin errors++; $display("FAIL fx_adcReq got %0b want 1", adcReq); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fx_busy got %0b want 1", busy); end
    step();
    adcAck = 1'b1;
    step();
    adcAck = 1'b0;
    e = expFx.pop_front();
    checks++; if (fxIn !== e) begin errors++; $display("FAIL fx_fxIn got %h want %h", fxIn, e); end
    checks++; if (fxStart !== 1'b1) begin errors++; $display("FAIL fx_start_on got %0b want 1", fxStart); end
    checks++; if (adcReq !== 1'b0) begin errors++; $display("FAIL fx_adcReq_drop got %0b want 0", adcReq); end
    step();
    checks++; if (fxStart !== 1'b0) begin errors++; $display("FAIL fx_start_pulse got %0b want 0", fxStart); end
    fxDone = 1'b1;
    step();
    fxDone = 1'b0;
    e = expDac.pop_front();
    checks++; if (dacReq !== 1'b1) begin errors++; $display("FAIL fx_dacReq got %0b want 1", dacReq); end
    checks++; if (dacData !== e) begin errors++; $display("FAIL fx_dacData got %h want %h", dacData, e); end
    step();
    dacAck = 1'b1;
    step();
    dacAck = 1'b0;
    checks++; if (dacReq !== 1'b0) begin errors++; $display("FAIL fx_dacReq_drop got %0b want 0", dacReq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fx_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_latency();
    int lat; bit st; bit got; logic [DW-1:0] d; logic [DW-1:0] fi; logic [DW-1:0] e;
    expDac.push_back(16'h5A5A);
    run_sample(16'h1111, 16'h5A5A, 1'b0, lat, st, got, d, fi);
    e = expDac.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL lat_dacReq_seen got %0b want 1", got); end
    checks++; if (lat != 4) begin errors++; $display("FAIL lat_cycles got %0d want 4", lat); end
    checks++; if (d !== e) begin errors++; $display("FAIL lat_dacData got %h want %h", d, e); end
  endtask

  task automatic test_bypass();
    int lat; bit st; bit got; logic [DW-1:0] d; logic [DW-1:0] fi; logic [DW-1:0] e;
    expDac.push_back(16'h0F0F);
    run_sample(16'h0F0F, 16'hDEAD, 1'b1, lat, st, got, d, fi);
    e = expDac.pop_front();
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL byp_fxStart got %0b want 0", st); end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL byp_dacReq_seen got %0b want 1", got); end
    checks++; if (lat != 2) begin errors++; $display("FAIL byp_cycles got %0d want 2", lat); end
    checks++; if (d !== e) begin errors++; $display("FAIL byp_dacData got %h want %h", d, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byp_busy_end got %0b want 0", busy); end
  endtask

  // Effect never answers: the stage must be abandoned after exactly TO cycles in FX.
  task automatic test_timeout();
    int n; bit sawReq;
    n = 0;
    sawReq = 1'b0;
    bypass     = 1'b0;
    adcData    = 16'h2222;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    adcAck = 1'b1;
    step();
    adcAck = 1'b0;
    checks++; if (fxStart !== 1'b1) begin errors++; $display("FAIL to_fx_entry got %0b want 1", fxStart); end
    while (busy && n < 2 * TO) begin
      step();
      n++;
      if (dacReq) sawReq = 1'b1;
    end
    checks++; if (n != TO) begin errors++; $display("FAIL to_cycles got %0d want %0d", n, TO); end
    checks++; if (timeoutFlag !== 1'b1) begin errors++; $display("FAIL to_flag got %0b want 1", timeoutFlag); end
    checks++; if (sawReq !== 1'b0) begin errors++; $display("FAIL to_dacReq got %0b want 0", sawReq); end
    checks++; if (dacData !== 16'h0F0F) begin errors++; $display("FAIL to_dacData got %h want 0f0f", dacData); end
    step();
    checks++; if (timeoutFlag !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", timeoutFlag); end
    clrStatus = 1'b1;
    step();
    clrStatus = 1'b0;
    checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("FAIL to_clear got %0b want 0", timeoutFlag); end
  endtask

  // DAC stalled while 300 ticks arrive; counter must saturate at 255.
  task automatic test_overrun();
    logic [DW-1:0] e;
    expDac.push_back(16'h5555);
    bypass     = 1'b1;
    adcData    = 16'h5555;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    adcAck = 1'b1;
    step();
    adcAck = 1'b0;
    checks++; if (dacReq !== 1'b1) begin errors++; $display("FAIL ovr_dacReq got %0b want 1", dacReq); end
    sampleTick = 1'b1;
    repeat (300) step();
    sampleTick = 1'b0;
    checks++; if (overrunCnt !== 8'd255) begin errors++; $display("FAIL ovr_sat got %0d want 255", overrunCnt); end
    checks++; if (dacReq !== 1'b1) begin errors++; $display("FAIL ovr_continue got %0b want 1", dacReq); end
    clrStatus = 1'b1;
    step();
    clrStatus = 1'b0;
    checks++; if (overrunCnt !== 8'd0) begin errors++; $display("FAIL ovr_clear got %0d want 0", overrunCnt); end
    // Drop and clear together: the drop is counted.
    sampleTick = 1'b1;
    clrStatus  = 1'b1;
    step();
    sampleTick = 1'b0;
    clrStatus  = 1'b0;
    checks++; if (overrunCnt !== 8'd1) begin errors++; $display("FAIL ovr_clr_prio got %0d want 1", overrunCnt); end
    e = expDac.pop_front();
    checks++; if (dacData !== e) begin errors++; $display("FAIL ovr_dacData got %h want %h", dacData, e); end
    dacAck = 1'b1;
    step();
    dacAck = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_end got %0b want 0", busy); end
    clrStatus = 1'b1;
    step();
    clrStatus = 1'b0;
  endtask

  task automatic test_tick_with_ack();
    logic [DW-1:0] e;
    expDac.push_back(16'h7777);
    bypass     = 1'b1;
    adcData    = 16'h7777;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    adcAck = 1'b1;
    step();
    adcAck = 1'b0;
    e = expDac.pop_front();
    checks++; if (dacData !== e) begin errors++; $display("FAIL twa_dacData got %h want %h", dacData, e); end
    dacAck     = 1'b1;
    sampleTick = 1'b1;
    step();
    dacAck     = 1'b0;
    sampleTick = 1'b0;
    checks++; if (overrunCnt !== 8'd1) begin errors++; $display("FAIL twa_overrun got %0d want 1", overrunCnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL twa_idle got %0b want 0", busy); end
    step();
    checks++; if (adcReq !== 1'b0) begin errors++; $display("FAIL twa_no_adc got %0b want 0", adcReq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL twa_still_idle got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat; bit st; bit got; logic [DW-1:0] d; logic [DW-1:0] fi; logic [DW-1:0] e;
    logic [DW-1:0] av[3];
    logic [DW-1:0] fv[3];
    logic          bv[3];
    av = '{16'hA001, 16'hA002, 16'hA003};
    fv = '{16'hF001, 16'hF002, 16'hF003};
    bv = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      expFx.push_back(av[i]);
      expDac.push_back(bv[i] ? av[i] : fv[i]);
    end
    for (int i = 0; i < 3; i++) begin
      run_sample(av[i], fv[i], bv[i], lat, st, got, d, fi);
      e = expDac.pop_front();
      checks++; if (got !== 1'b1 || d !== e) begin errors++; $display("FAIL b2b_dac[%0d] got %h req=%0b want %h", i, d, got, e); end
      e = expFx.pop_front();
      checks++; if (fi !== e) begin errors++; $display("FAIL b2b_fxIn[%0d] got %h want %h", i, fi, e); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit st; bit got; logic [DW-1:0] d; logic [DW-1:0] fi; logic [DW-1:0] e;
    bypass     = 1'b1;
    adcData    = 16'h3333;
    sampleTick = 1'b1;
    step();
    sampleTick = 1'b0;
    adcAck = 1'b1;
    step();
    adcAck = 1'b0;
    checks++; if (dacReq !== 1'b1) begin errors++; $display("FAIL rm_dacReq_pre got %0b want 1", dacReq); end
    #2;
    rstN = 1'b0;
    #1;
    checks++; if (dacReq !== 1'b0) begin errors++; $display("FAIL rm_dacReq got %0b want 0", dacReq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %0b want 0", busy); end
    checks++; if (dacData !== 16'h0) begin errors++; $display("FAIL rm_dacData got %h want 0", dacData); end
    checks++; if (fxIn !== 16'h0) begin errors++; $display("FAIL rm_fxIn got %h want 0", fxIn); end
    checks++; if (overrunCnt !== 8'd0) begin errors++; $display("FAIL rm_overrun got %0d want 0", overrunCnt); end
    rstN = 1'b1;
    step();
    expDac.push_back(16'hCAFE);
    run_sample(16'hBEEF, 16'hCAFE, 1'b0, lat, st, got, d, fi);
    e = expDac.pop_front();
    checks++; if (got !== 1'b1 || d !== e) begin errors++; $display("FAIL rm_after got %h req=%0b want %h", d, got, e); end
    checks++; if (fi !== 16'hBEEF) begin errors++; $display("FAIL rm_after_fxIn got %h want beef", fi); end
  endtask

  initial begin
    sampleTick = 1'b0;
    bypass     = 1'b0;
    clrStatus  = 1'b0;
    adcAck     = 1'b0;
    adcData    = '0;
    fxDone     = 1'b0;
    fxOut      = '0;
    dacAck     = 1'b0;
    test_reset();
    test_fx_path();
    test_latency();
    test_bypass();
    test_timeout();
    test_overrun();
    test_tick_with_ack();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
